input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 122 ++++++++++++
 tb/tb_input_conditioner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Input conditioner for the drink machine front panel.
// Seven raw switch channels (coin 1, coin 2, cancel, four drink buttons) are
// normalised to active-high, passed through a two-flop synchronizer and
// debounced by a per-channel stability counter. An accepted press (debounced
// level rising 0->1) yields a single registered one-cycle pulse; releases are
// silent. The drink pulses are then arbitrated: exactly one drink with no
// cancel gives a sel pulse, two or more drinks give multi_err, and cancel
// suppresses a lone drink request.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m1_in,
  input  logic       m2_in,
  input  logic       cancel_in,
  input  logic [3:0] btn_in,
  output logic       M1,
  output logic       M2,
  output logic       cancel,
  output logic [3:0] sel,
  output logic       multi_err
);

  // Channel map: 0 = coin 1, 1 = coin 2, 2 = cancel, 3..6 = btn[0..3].
  localparam int N_CH = 7;
  localparam int CH_M1 = 0;
  localparam int CH_M2 = 1;
  localparam int CH_CANCEL = 2;
  localparam int CH_BTN0 = 3;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [3:0]      btn_lvl;
  logic [N_CH-1:0] raw_lvl;

  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;
  logic [N_CH-1:0] stable;
  logic [N_CH-1:0] pulse;
  logic [CW-1:0]   cnt [N_CH];

  logic [N_CH-1:0] stable_next;
  logic [N_CH-1:0] pulse_next;
  logic [CW-1:0]   cnt_next [N_CH];

  logic [3:0]      btn_pulse;
  logic [2:0]      btn_count;

  // Buttons are normalised before the synchronizer so every downstream stage
  // sees active-high levels.
  assign btn_lvl = BTN_ACTIVE_LOW ? ~btn_in : btn_in;
  assign raw_lvl = {btn_lvl, cancel_in, m2_in, m1_in};

  // Two-flop synchronizer; the only consumer of the raw levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_lvl;
      s2 <= s1;
    end
  end

  // Debounce decision per channel: the counter only advances while the
  // synchronized level disagrees with the debounced one, and any agreement
  // restarts it, so short excursions never reach the terminal count.
  always_comb begin
    stable_next = stable;
    pulse_next  = '0;
    cnt_next    = cnt;
    for (int i = 0; i < N_CH; i++) begin
      if (s2[i] == stable[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] >= CNT_LAST) begin
        stable_next[i] = ~stable[i];
        cnt_next[i]    = '0;
        pulse_next[i]  = ~stable[i];
      end else begin
        cnt_next[i] = cnt[i] + CNT_ONE;
      end
    end
  end

  // Debounced level, counter and press-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      pulse  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable <= stable_next;
      pulse  <= pulse_next;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign btn_pulse = pulse[CH_BTN0 +: 4];
  assign btn_count = 3'($countones(btn_pulse));

  // Output arbitration on the registered pulses: coins and cancel pass
  // straight through; drink requests need exactly one button and no cancel.
  always_comb begin
    M1        = pulse[CH_M1];
    M2        = pulse[CH_M2];
    cancel    = pulse[CH_CANCEL];
    multi_err = (btn_count > 3'd1);
    sel       = '0;
    if (btn_count == 3'd1 && !pulse[CH_CANCEL]) begin
      sel = btn_pulse;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DEBOUNCE_CYCLES=4 and
// active-low buttons. Each driven edge pushes its expected output word into
// a queue; the word is popped and compared just after that edge.
module tb_input_conditioner;

  localparam int DB = 4;
  localparam logic [3:0] BTN_IDLE = 4'b1111;

  typedef struct packed {
    logic       m1;
    logic       m2;
    logic       cn;
    logic [3:0] sel;
    logic       merr;
  } out_t;

  typedef struct {
    string      name;
    logic       m1;
    logic       m2;
    logic       cn;
    logic [3:0] btn;
    int         hold;
    int         pedge;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m1_in = 1'b0;
  logic       m2_in = 1'b0;
  logic       cancel_in = 1'b0;
  logic [3:0] btn_in = BTN_IDLE;
  logic       M1;
  logic       M2;
  logic       cancel;
  logic [3:0] sel;
  logic       multi_err;

  int   checks = 0;
  int   failures = 0;
  out_t exp_q[$];
  vec_t vecs[$];

  input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m1_in    (m1_in),
    .m2_in    (m2_in),
    .cancel_in(cancel_in),
    .btn_in   (btn_in),
    .M1       (M1),
    .M2       (M2),
    .cancel   (cancel),
    .sel      (sel),
    .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic out_t mk_out(input logic m1, input logic m2, input logic cn,
                                  input logic [3:0] s, input logic merr);
    out_t o;
    o.m1 = m1; o.m2 = m2; o.cn = cn; o.sel = s; o.merr = merr;
    return o;
  endfunction

  function automatic vec_t mk_vec(input string name, input logic m1, input logic m2,
                                  input logic cn, input logic [3:0] btn, input int hold,
                                  input int pedge, input out_t exp);
    vec_t v;
    v.name = name; v.m1 = m1; v.m2 = m2; v.cn = cn; v.btn = btn;
    v.hold = hold; v.pedge = pedge; v.exp = exp;
    return v;
  endfunction

  // Push the expectation for the coming edge, clock it, then pop and compare.
  task automatic step(input string tag, input int edge_no, input out_t exp);
    out_t got;
    out_t want;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    got  = {M1, M2, cancel, sel, multi_err};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s edge %0d: got {M1,M2,cancel,sel,multi_err}=%b expected %b",
               tag, edge_no, got, want);
    end
  endtask

  task automatic set_idle();
    m1_in = 1'b0; m2_in = 1'b0; cancel_in = 1'b0; btn_in = BTN_IDLE;
  endtask

  task automatic do_reset(input string tag);
    set_idle();
    rst = 1'b1;
    step({tag, "_rst"}, 0, '0);
    step({tag, "_rst"}, 0, '0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step({tag, "_idle"}, 0, '0);
  endtask

  initial begin
    vecs.push_back(mk_vec("m1_press",     1, 0, 0, BTN_IDLE, 12, 6, mk_out(1, 0, 0, 4'b0000, 0)));
    vecs.push_back(mk_vec("m2_press",     0, 1, 0, BTN_IDLE, 12, 6, mk_out(0, 1, 0, 4'b0000, 0)));
    vecs.push_back(mk_vec("cancel_press", 0, 0, 1, BTN_IDLE,  8, 6, mk_out(0, 0, 1, 4'b0000, 0)));
    vecs.push_back(mk_vec("expreso",      0, 0, 0, 4'b1110,   9, 6, mk_out(0, 0, 0, 4'b0001, 0)));
    vecs.push_back(mk_vec("cafe_leche",   0, 0, 0, 4'b1101,   9, 6, mk_out(0, 0, 0, 4'b0010, 0)));
    vecs.push_back(mk_vec("mocca",        0, 0, 0, 4'b0111,   9, 6, mk_out(0, 0, 0, 4'b1000, 0)));
    vecs.push_back(mk_vec("two_drinks",   0, 0, 0, 4'b1010,  12, 6, mk_out(0, 0, 0, 4'b0000, 1)));
    vecs.push_back(mk_vec("cancel_drink", 0, 0, 1, 4'b1101,  10, 6, mk_out(0, 0, 1, 4'b0000, 0)));
    vecs.push_back(mk_vec("cancel_multi", 0, 0, 1, 4'b1010,  10, 6, mk_out(0, 0, 1, 4'b0000, 1)));
    vecs.push_back(mk_vec("m1_m2_same",   1, 1, 0, BTN_IDLE, 10, 6, mk_out(1, 1, 0, 4'b0000, 0)));
    vecs.push_back(mk_vec("hold_exact_4", 1, 0, 0, BTN_IDLE, DB, 6, mk_out(1, 0, 0, 4'b0000, 0)));
    vecs.push_back(mk_vec("glitch_3",     1, 0, 0, BTN_IDLE, DB - 1, 0, mk_out(0, 0, 0, 4'b0000, 0)));
    vecs.push_back(mk_vec("btn_glitch_1", 0, 0, 0, 4'b1011,   1, 0, mk_out(0, 0, 0, 4'b0000, 0)));

    // Table: press applied before edge 1, held for 'hold' edges, then released.
    // The release is debounced within the 20 edges and must stay silent.
    foreach (vecs[k]) begin
      do_reset(vecs[k].name);
      m1_in = vecs[k].m1; m2_in = vecs[k].m2;
      cancel_in = vecs[k].cn; btn_in = vecs[k].btn;
      for (int e = 1; e <= 20; e++) begin
        step(vecs[k].name, e, (e == vecs[k].pedge) ? vecs[k].exp : out_t'('0));
        if (e == vecs[k].hold) set_idle();
      end
    end

    // Cancel chattering 3 high / 3 low, four times: never accepted.
    do_reset("chatter");
    for (int e = 1; e <= 30; e++) begin
      cancel_in = (e <= 24) && ((((e - 1) / 3) % 2) == 0);
      step("chatter", e, '0);
    end

    // Reset mid-count with coin 2 held: restarts from zero, pulses at edge 10.
    do_reset("m2_midrst");
    m2_in = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      rst = (e == 4);
      step("m2_midrst", e, (e == 10) ? mk_out(0, 1, 0, 4'b0000, 0) : out_t'('0));
    end
    set_idle();

    // Input already asserted across reset: treated as a fresh press.
    do_reset("hold_thru_rst");
    rst = 1'b1;
    m1_in = 1'b1;
    step("hold_thru_rst", 0, '0);
    step("hold_thru_rst", 0, '0);
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step("hold_thru_rst", e, (e == DB + 2) ? mk_out(1, 0, 0, 4'b0000, 0) : out_t'('0));
    end
    set_idle();

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
